pagerank_sweep_ctrl: RTL and testbench

Sequencer that drives the PageRank rank register file. On a start pulse it sweeps every node address, reads each rank, computes the damped update new = base + ((damp × old) >> FRAC_BITS), and writes the result back in place. It repeats sweeps until the largest per-node change is within threshold or an iteration cap is reached. It connects directly to the register file's read/write port: its write port feeds the file, and it consumes the file's registered read data.

---
 rtl/pagerank_sweep_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pagerank_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_sweep_ctrl.sv
// PageRank sweep sequencer: reads each rank, writes back base + ((damp*old) >> FRAC_BITS)
// one cycle later, and repeats sweeps until the max change is within threshold or MAX_ITER.
module pagerank_sweep_ctrl #(
  parameter int unsigned WIDTH     = 21,
  parameter int unsigned ADDWIDTH  = 5,
  parameter int unsigned NUM_NODES = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned MAX_ITER  = 16,
  parameter int unsigned ITERW     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             damp,
  input  logic [WIDTH-1:0]             base,
  input  logic [WIDTH-1:0]             threshold,
  output logic                         rf_readEnable,
  output logic [ADDWIDTH-1:0]          rf_source,
  input  logic [WIDTH-1:0]             rf_dataOut,
  output logic                         rf_writeEnable,
  output logic [ADDWIDTH-1:0]          rf_dest,
  output logic [WIDTH-1:0]             rf_dataIn,
  output logic                         busy,
  output logic                         done,
  output logic                         converged,
  output logic [ITERW-1:0]             iter_count,
  output logic [WIDTH+ADDWIDTH-1:0]    rank_sum
);

  localparam int unsigned SUMW  = WIDTH + ADDWIDTH;
  localparam int unsigned PRODW = 2 * WIDTH;
  localparam int unsigned UPDW  = PRODW + 1;
  localparam logic [ADDWIDTH-1:0] LAST_ADDR = ADDWIDTH'(NUM_NODES - 1);
  localparam logic [ITERW-1:0]    ITER_CAP  = ITERW'(MAX_ITER);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CHECK, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDWIDTH-1:0]   src_q, src_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDWIDTH-1:0]   dest_q, dest_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  conv_q, conv_d;
  logic [ITERW-1:0]      iter_q, iter_d;
  logic [SUMW-1:0]       rsum_q, rsum_d;
  logic [WIDTH-1:0]      maxd_q, maxd_d;
  logic [SUMW-1:0]       sum_q, sum_d;

  logic [PRODW-1:0]      prod_c;
  logic [UPDW-1:0]       upd_c;
  logic [WIDTH-1:0]      new_c;
  logic [WIDTH-1:0]      delta_c;
  logic [WIDTH-1:0]      maxd_upd_c;
  logic [SUMW-1:0]       sum_upd_c;

  // Damped update on the registered read data, saturated to WIDTH bits
  always_comb begin
    prod_c  = PRODW'(damp) * PRODW'(rf_dataOut);
    upd_c   = UPDW'(prod_c >> FRAC_BITS) + UPDW'(base);
    new_c   = (|upd_c[UPDW-1:WIDTH]) ? {WIDTH{1'b1}} : upd_c[WIDTH-1:0];
    delta_c = (new_c >= rf_dataOut) ? (new_c - rf_dataOut) : (rf_dataOut - new_c);
    maxd_upd_c = (wr_en_q && (delta_c > maxd_q)) ? delta_c : maxd_q;
    sum_upd_c  = wr_en_q ? (sum_q + SUMW'(new_c)) : sum_q;
  end

  // Next state; the write stage is the read stage delayed by one cycle
  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    src_d   = src_q;
    wr_en_d = rd_en_q;
    dest_d  = src_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    conv_d  = conv_q;
    iter_d  = iter_q;
    rsum_d  = rsum_q;
    maxd_d  = maxd_upd_c;
    sum_d   = sum_upd_c;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
          src_d   = '0;
          busy_d  = 1'b1;
          conv_d  = 1'b0;
          iter_d  = '0;
          maxd_d  = '0;
          sum_d   = '0;
        end
      end
      S_READ: begin
        if (src_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d = 1'b1;
          src_d   = src_q + ADDWIDTH'(1);
        end
      end
      S_DRAIN: begin
        // Results settle here so they are already stable throughout CHECK
        state_d = S_CHECK;
        iter_d  = iter_q + ITERW'(1);
        rsum_d  = sum_upd_c;
        conv_d  = (maxd_upd_c <= threshold);
      end
      S_CHECK: begin
        if (conv_q || (iter_q == ITER_CAP)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
          rd_en_d = 1'b1;
          src_d   = '0;
          maxd_d  = '0;
          sum_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
      src_q   <= '0;
      wr_en_q <= 1'b0;
      dest_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      iter_q  <= '0;
      rsum_q  <= '0;
      maxd_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      src_q   <= src_d;
      wr_en_q <= wr_en_d;
      dest_q  <= dest_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      conv_q  <= conv_d;
      iter_q  <= iter_d;
      rsum_q  <= rsum_d;
      maxd_q  <= maxd_d;
      sum_q   <= sum_d;
    end
  end

  assign rf_readEnable  = rd_en_q;
  assign rf_source      = src_q;
  assign rf_writeEnable = wr_en_q;
  assign rf_dest        = dest_q;
  // Write data must track the file's read data in the same cycle, so it is gated, not registered
  assign rf_dataIn      = wr_en_q ? new_c : '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign converged      = conv_q;
  assign iter_count     = iter_q;
  assign rank_sum       = rsum_q;

endmodule

// File: tb/tb_pagerank_sweep_ctrl.sv
// Bench for pagerank_sweep_ctrl: register-file model, array-based sweep reference model,
// directed cases from the plan plus randomized runs, and a cycle-by-cycle pipeline monitor.
module tb_pagerank_sweep_ctrl;

  localparam int unsigned W  = 21;
  localparam int unsigned AW = 5;
  localparam int unsigned N  = 32;
  localparam int unsigned FB = 16;
  localparam int unsigned MI = 16;
  localparam int unsigned IW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [W-1:0]      damp, base, threshold;
  logic              rf_readEnable, rf_writeEnable;
  logic [AW-1:0]     rf_source, rf_dest;
  logic [W-1:0]      rf_dataOut, rf_dataIn;
  logic              busy, done, converged;
  logic [IW-1:0]     iter_count;
  logic [W+AW-1:0]   rank_sum;

  always #5 clk = ~clk;

  pagerank_sweep_ctrl #(
    .WIDTH(W), .ADDWIDTH(AW), .NUM_NODES(N), .FRAC_BITS(FB), .MAX_ITER(MI), .ITERW(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .damp(damp), .base(base), .threshold(threshold),
    .rf_readEnable(rf_readEnable), .rf_source(rf_source), .rf_dataOut(rf_dataOut),
    .rf_writeEnable(rf_writeEnable), .rf_dest(rf_dest), .rf_dataIn(rf_dataIn),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count), .rank_sum(rank_sum)
  );

  // Register file with registered read data
  logic [W-1:0] mem [N];
  logic [W-1:0] init_mem [N];
  logic         preload;
  logic [W-1:0] rd_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(N); i++) mem[i] <= init_mem[i];
    end else if (rf_writeEnable) begin
      mem[rf_dest] <= rf_dataIn;
    end
    if (rf_readEnable) rd_q <= mem[rf_source];
  end
  assign rf_dataOut = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] upd(input logic [W-1:0] d, input logic [W-1:0] b,
                                       input logic [W-1:0] o);
    longint unsigned r;
    longint unsigned smax;
    smax = (64'd1 << W) - 64'd1;
    r = ((64'(d) * 64'(o)) >> FB) + 64'(b);
    if (r > smax) r = smax;
    return W'(r);
  endfunction

  // Reference: whole sweeps over an array until threshold or cap
  logic [W-1:0]    exp_mem [N];
  int              exp_iter;
  bit              exp_conv;
  longint unsigned exp_sum;
  int              exp_done;

  task automatic model_run(input logic [W-1:0] d, input logic [W-1:0] b, input logic [W-1:0] t);
    longint unsigned maxd, nv, dl;
    for (int i = 0; i < int'(N); i++) exp_mem[i] = init_mem[i];
    exp_iter = 0;
    exp_conv = 0;
    forever begin
      exp_iter++;
      maxd = 0;
      exp_sum = 0;
      for (int k = 0; k < int'(N); k++) begin
        nv = 64'(upd(d, b, exp_mem[k]));
        dl = (nv >= 64'(exp_mem[k])) ? nv - 64'(exp_mem[k]) : 64'(exp_mem[k]) - nv;
        if (dl > maxd) maxd = dl;
        exp_sum += nv;
        exp_mem[k] = W'(nv);
      end
      if (maxd <= 64'(t)) begin
        exp_conv = 1;
        break;
      end
      if (exp_iter == int'(MI)) break;
    end
    exp_done = exp_iter * (int'(N) + 2) + 1;
  endtask

  // Pipeline monitor: write follows read by one cycle with data derived from the read data
  bit           mon_en = 0;
  logic         prev_rd = 1'b0;
  logic [AW-1:0] prev_src = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("wr_follows_rd", 64'(rf_writeEnable), 64'(prev_rd));
      if (rf_writeEnable) begin
        check_eq("wr_dest", 64'(rf_dest), 64'(prev_src));
        check_eq("wr_data", 64'(rf_dataIn), 64'(upd(damp, base, rf_dataOut)));
      end
      if (rf_writeEnable && rf_readEnable)
        check_eq("rw_same_addr", 64'(rf_dest == rf_source), 64'(0));
    end
    prev_rd  = rf_readEnable;
    prev_src = rf_source;
  end

  task automatic chk_idle(input string pfx);
    check_eq({pfx, "_busy"}, 64'(busy), 64'(0));
    check_eq({pfx, "_done"}, 64'(done), 64'(0));
    check_eq({pfx, "_conv"}, 64'(converged), 64'(0));
    check_eq({pfx, "_iter"}, 64'(iter_count), 64'(0));
    check_eq({pfx, "_rsum"}, 64'(rank_sum), 64'(0));
    check_eq({pfx, "_rden"}, 64'(rf_readEnable), 64'(0));
    check_eq({pfx, "_wren"}, 64'(rf_writeEnable), 64'(0));
    check_eq({pfx, "_src"}, 64'(rf_source), 64'(0));
    check_eq({pfx, "_dest"}, 64'(rf_dest), 64'(0));
    check_eq({pfx, "_wdata"}, 64'(rf_dataIn), 64'(0));
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] d, input logic [W-1:0] b,
                          input logic [W-1:0] t, input bit poke);
    int cyc;
    bit seen;
    int errs;
    do_preload();
    model_run(d, b, t);
    damp = d;
    base = b;
    threshold = t;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq({tag, "_busy_c1"}, 64'(busy), 64'(1));
      if (poke && cyc == 10) start = 1'b1;
      if (poke && cyc == 11) start = 1'b0;
      seen = done;
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'(1));
    check_eq({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
    check_eq({tag, "_converged"}, 64'(converged), 64'(exp_conv));
    check_eq({tag, "_iter"}, 64'(iter_count), 64'(exp_iter));
    check_eq({tag, "_rank_sum"}, 64'(rank_sum), exp_sum);
    @(negedge clk);
    check_eq({tag, "_busy_after"}, 64'(busy), 64'(0));
    check_eq({tag, "_done_after"}, 64'(done), 64'(0));
    errs = 0;
    for (int i = 0; i < int'(N); i++) if (mem[i] !== exp_mem[i]) errs++;
    check_eq({tag, "_rf_entries_bad"}, 64'(errs), 64'(0));
  endtask

  task automatic reset_case();
    int cyc;
    int errs;
    logic [W-1:0] d, b;
    for (int i = 0; i < int'(N); i++) init_mem[i] = W'($urandom);
    d = W'($urandom_range(0, 65535));
    b = W'($urandom_range(1, 40000));
    do_preload();
    damp = d;
    base = b;
    threshold = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    mon_en = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_idle("midrst");
    @(negedge clk);
    chk_idle("midrst_held");
    errs = 0;
    for (int i = 0; i < int'(N); i++)
      if (mem[i] !== ((i <= 18) ? upd(d, b, init_mem[i]) : init_mem[i])) errs++;
    check_eq("midrst_rf_entries_bad", 64'(errs), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("midrst_release");
    mon_en = 1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    damp = '0;
    base = '0;
    threshold = '0;
    preload = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("post_rst");
    mon_en = 1;

    for (int i = 0; i < int'(N); i++) init_mem[i] = W'(i);
    run_case("fixed", W'(0), W'(100), W'(0), 0);
    check_eq("fixed_literal_sum", 64'(rank_sum), 64'(3200));

    for (int i = 0; i < int'(N); i++) init_mem[i] = W'(500);
    run_case("ident", W'(1 << 16), W'(0), W'(0), 0);
    check_eq("ident_literal_sum", 64'(rank_sum), 64'(16000));

    for (int i = 0; i < int'(N); i++) init_mem[i] = W'(0);
    run_case("cap", W'(1 << 16), W'(1), W'(0), 0);
    check_eq("cap_literal_iter", 64'(iter_count), 64'(16));

    for (int i = 0; i < int'(N); i++) init_mem[i] = W'(21'h1FFFFF);
    run_case("sat", W'(21'h1FFFFF), W'(21'h1FFFFF), W'(0), 0);
    check_eq("sat_literal_sum", 64'(rank_sum), 64'(32) * 64'(21'h1FFFFF));

    for (int i = 0; i < int'(N); i++) init_mem[i] = W'($urandom);
    run_case("poke", W'($urandom_range(0, 60000)), W'($urandom_range(0, 30000)),
             W'($urandom_range(0, 500)), 1);

    reset_case();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(N); i++) init_mem[i] = W'($urandom);
      run_case($sformatf("rand%0d", r), W'($urandom_range(0, 65535)),
               W'($urandom_range(0, 50000)), W'($urandom_range(0, 3000)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
